// File: rtl/tt_um_toivoh_serial_alu.sv
// ============================================================================
// Module   : tt_um_toivoh_serial_alu
// Brief    : Byte-loaded operands, digit-serial ADD/SUB, shift-add MUL, byte
//            readback. Optional latency counter under SERIAL_ALU_LATENCY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_um_toivoh_serial_alu #(
    parameter int LOG2_BYTES_IN = 3,
    parameter int LOG2_DIGIT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);
    localparam int BYTES_IN = 1 << LOG2_BYTES_IN;
    localparam int W        = BYTES_IN * 4;
    localparam int R        = 2 * W;
    localparam int D        = 1 << LOG2_DIGIT;
    localparam int N_ADD    = W / D;
    localparam int N_MUL    = W;
    localparam int CW       = $clog2(W);

    localparam logic [CW-1:0] STEP_ADD = CW'(N_ADD - 1);
    localparam logic [CW-1:0] STEP_MUL = CW'(N_MUL - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 op_q, op_d;
    logic [R-1:0]               input_data_q, input_data_d;
    logic [R-1:0]               output_data_q, output_data_d;
    logic [W-1:0]               a_q, a_d;
    logic [W-1:0]               b_q, b_d;
    logic [R-1:0]               acc_q, acc_d;
    logic                       carry_q, carry_d;
    logic [CW-1:0]              step_q, step_d;

    logic                       cmd;
    logic [LOG2_BYTES_IN-1:0]   sel_in;
    logic [LOG2_BYTES_IN-1:0]   sel_out;
    logic [D:0]                 digit_sum;
    logic [W+D-1:0]             add_cat;
    logic [W:0]                 mul_upper;
    logic [R-1:0]               nop_result;
    logic [R-1:0]               result;

    assign cmd     = uio_in[3];
    assign sel_in  = uio_in[LOG2_BYTES_IN-1:0];
    assign sel_out = uio_in[4 +: LOG2_BYTES_IN];

    assign digit_sum = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, carry_q};
    assign add_cat   = {digit_sum[D-1:0], acc_q[W-1:0]};
    assign mul_upper = {1'b0, acc_q[R-1:W]} + ({1'b0, a_q} & {(W+1){b_q[0]}});

`ifdef SERIAL_ALU_LATENCY_EN
    logic [15:0] lat_cnt_q, lat_cnt_d;
    logic [15:0] lat_prev_q, lat_prev_d;

    // The finished count is snapshotted at the next start so a NOP can report it.
    always_comb begin
        lat_cnt_d  = lat_cnt_q;
        lat_prev_d = lat_prev_q;
        if (state_q == S_IDLE) begin
            if (cmd) begin
                lat_prev_d = lat_cnt_q;
                lat_cnt_d  = '0;
            end
        end else if (lat_cnt_q != 16'hFFFF) begin
            lat_cnt_d = lat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_q  <= '0;
            lat_prev_q <= '0;
        end else begin
            lat_cnt_q  <= lat_cnt_d;
            lat_prev_q <= lat_prev_d;
        end
    end

    assign nop_result = R'(lat_prev_q);
`else
    assign nop_result = '0;
`endif

    always_comb begin
        case (op_q)
            OP_ADD,
            OP_SUB:  result = R'({carry_q, acc_q[W-1:0]});
            OP_MUL:  result = acc_q;
            default: result = nop_result;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        input_data_d  = input_data_q;
        output_data_d = output_data_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_d         = acc_q;
        carry_d       = carry_q;
        step_d        = step_q;
        case (state_q)
            S_IDLE: begin
                if (cmd) begin
                    op_d    = ui_in[1:0];
                    state_d = S_LOAD;
                end else begin
                    input_data_d[{sel_in, 3'b000} +: 8] = ui_in;
                end
            end
            S_LOAD: begin
                // SUB is x + ~y + 1.
                a_d     = input_data_q[W-1:0];
                b_d     = (op_q == OP_SUB) ? ~input_data_q[R-1:W] : input_data_q[R-1:W];
                acc_d   = '0;
                carry_d = (op_q == OP_SUB);
                case (op_q)
                    OP_ADD, OP_SUB: step_d = STEP_ADD;
                    OP_MUL:         step_d = STEP_MUL;
                    default:        step_d = '0;
                endcase
                state_d = S_RUN;
            end
            S_RUN: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        acc_d[W-1:0] = add_cat[W+D-1:D];
                        carry_d      = digit_sum[D];
                        a_d          = a_q >> D;
                        b_d          = b_q >> D;
                    end
                    OP_MUL: begin
                        acc_d = {mul_upper, acc_q[W-1:1]};
                        b_d   = b_q >> 1;
                    end
                    default: ;
                endcase
                if (step_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            S_DONE: begin
                output_data_d = result;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            input_data_q  <= '0;
            output_data_q <= '0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            carry_q       <= 1'b0;
            step_q        <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            input_data_q  <= input_data_d;
            output_data_q <= output_data_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_q         <= acc_d;
            carry_q       <= carry_d;
            step_q        <= step_d;
        end
    end

    assign uo_out  = output_data_q[{sel_out, 3'b000} +: 8];
    assign uio_out = {state_q != S_IDLE, 7'b0};
    assign uio_oe  = 8'h80;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in};

endmodule

`default_nettype wire

// File: doc/tt_um_toivoh_serial_alu.md
Name: tt_um_toivoh_serial_alu

Overview:
- Second-generation operand/result test harness for a TinyTapeout tile.
- Operands are loaded byte-wise through ui_in. A multi-cycle digit-serial datapath runs ADD, SUB, MUL or NOP on command. The registered result is read back byte-wise through uo_out.
- Adds start/busy handshake, selectable operation, parametrised digit width and an optional latency counter for measuring serial-datapath timing in silicon.

Parameters:
- LOG2_BYTES_IN, 3: input bytes = 2^LOG2_BYTES_IN; operand width W = BYTES_IN*4 bits each for x and y (valid 1..3).
- LOG2_DIGIT, 0: ADD/SUB process D = 2^LOG2_DIGIT bits per cycle; must satisfy D <= W.
- Derived, not overridable: BYTES_OUT = BYTES_IN; result width R = 2W; N_ADD = W/D; N_MUL = W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enabled; ignored by logic
- ui_in  in  8  data byte for writes; op code on command cycles
- uio_in  in  8  [2:0] sel_in, [3] cmd, [6:4] sel_out, [7] unused (output pin)
- uio_out  out  8  [7] busy, [6:0] = 0
- uio_oe  out  8  constant 8'h80
- uo_out  out  8  result byte sel_out, combinational mux of output_data

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset clears:
  - input_data, output_data, working registers, step counter
  - state = IDLE, so busy = 0 and uo_out = 0
- Input layout: x = input_data[W-1:0], y = input_data[2W-1:W].
- Write rule: each edge with cmd=0 and state IDLE loads ui_in into input byte sel_in. sel_in bits above LOG2_BYTES_IN-1 are ignored. Writes while busy are dropped.
- Command rule: an edge with cmd=1 and state IDLE starts op = ui_in[1:0]:
  - 00 ADD: x+y
  - 01 SUB: x-y
  - 10 MUL: x*y, unsigned
  - 11 NOP: result 0, or the latency count with the optional feature
- cmd=1 while busy is ignored. Holding cmd=1 for several cycles restarts on the first IDLE edge after completion; the bench pulses cmd for one cycle.
- FSM states: IDLE -> LOAD -> RUN -> DONE -> IDLE.
  - LOAD, 1 cycle: copy x, y into working regs; clear accumulator and carry (SUB: carry=1, y inverted); step counter = N-1. N = N_ADD for ADD/SUB, N_MUL for MUL, 1 for NOP.
  - RUN, N cycles, step counter decrements:
    - ADD/SUB: add D LSBs plus carry, shift the D result bits into the accumulator MSB end, shift operands right by D.
    - MUL: if multiplier LSB = 1, add multiplicand into the upper half of the 2W accumulator with carry; then shift the accumulator and multiplier right by 1.
  - RUN exits to DONE on the edge where the counter is 0.
  - DONE, 1 cycle: write output_data, then go to IDLE.
- Timing: start edge = edge 0. output_data and busy=0 are both visible after edge N+2. busy is uio_out[7], registered (state != IDLE), high from edge 0 through edge N+1.
- Width rules, results zero-extended to R:
  - ADD: result[W] = carry out.
  - SUB: result[W] = final carry (1 = no borrow); result[W-1:0] = x-y mod 2^W.
  - MUL: full 2W product, no truncation.
- output_data holds the last result until the next DONE. Operand writes never alter it.
- Reset mid-operation: aborts immediately; everything returns to reset values and no partial result is written.

Optional Feature:
- Macro SERIAL_ALU_LATENCY_EN.
- Defined: a 16-bit counter clears on the start edge and increments every edge while busy, saturating at 16'hFFFF. NOP returns the count of the previous operation in result[15:0], upper bits 0. The count equals N+2 for that operation (the NOP's own start does not disturb it until DONE).
- Undefined: counter absent; NOP returns 0.

Test Plan:
- Defaults (W=32, D=1). Write x=32'hFFFFFFFF, y=32'h00000001, pulse ADD -> busy high for exactly 34 edges. Then output byte 4 = 8'h01, bytes 0-3 and 5-7 = 8'h00.
- x=5, y=7, SUB -> result[31:0]=32'hFFFFFFFE, result[32]=0. Swap to x=7, y=5 -> result = 33'h1_00000002.
- x=y=32'hFFFFFFFF, MUL -> bytes 7..0 = FF FF FF FE 00 00 00 01, completed 34 edges after start.
- During a running MUL, write byte 0 = 8'hAA and pulse cmd=1 with SUB -> both ignored; the MUL result is correct and input byte 0 is unchanged.
- Assert rst_n low mid-RUN of an ADD -> busy and uo_out drop to 0 asynchronously. After release, output_data = 0 and a new ADD 3+4 returns 7.
- With SERIAL_ALU_LATENCY_EN, LOG2_DIGIT=2: ADD then NOP -> NOP result = 10 (N=8, plus 2). Without the macro, NOP result = 0.
